fp_normalize: RTL

FP_NORMALIZE -- requirements
Module: fp_normalize

---
 rtl/fp_pkg.sv | 22 ++
 rtl/fp_lzc.sv | 24 ++
 rtl/fp_normalize.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: constants shared by the floating-point normalizer slice.
//   - default exponent/mantissa widths (IEEE-754 single)
//   - normalizer FSM state encoding
//   - bit positions inside the 3-bit flags vector {overflow, underflow, zero}
//   - EXP_MAX, the all-ones (Inf/NaN) exponent for the default width
package fp_pkg;

    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned MAN_W_DEF = 23;
    localparam int unsigned EXP_MAX   = (1 << EXP_W_DEF) - 1;

    localparam int unsigned FLAG_OVF  = 2;
    localparam int unsigned FLAG_UNF  = 1;
    localparam int unsigned FLAG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter.
// Ports:
//   din  [W-1:0]            value to scan, MSB first
//   cnt  [$clog2(W+1)-1:0]  number of zeros above the highest set bit (W when din == 0)
module fp_lzc #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0]             din,
    output logic [$clog2(W+1)-1:0]   cnt
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    // Scan upward so the highest set bit writes last and wins.
    always_comb begin
        cnt = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                cnt = CNT_W'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_normalize.sv
// fp_normalize: normalizes a raw adder mantissa sum and packs an IEEE-754 style result.
// Build option: define FP_NORM_FAST_LZC_EN to normalize left in a single NORM cycle using
// the fp_lzc leading-zero counter; otherwise the sum is shifted one bit per NORM cycle.
// Packed results are identical in both builds; only latency differs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   in_sign, in_exp     sign and exponent of the larger operand
//   in_sum              raw sum: [MAN_W+1] carry, [MAN_W] hidden bit
//   out_valid/out_ready result handshake
//   out_result          packed {sign, exp, man}
//   out_flags           {overflow, underflow, zero}
module fp_normalize
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [MAN_W+1:0]       in_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [2:0]             out_flags
);

    localparam int unsigned SUM_W = MAN_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

    state_t             state;
    logic               sign_q;
    logic [EXP_W-1:0]   exp_q;
    logic [SUM_W-1:0]   sum_q;

    // Operand as seen by the NORM decision (pre-shifted in the fast build).
    logic [EXP_W-1:0]   n_exp;
    logic [SUM_W-1:0]   n_sum;
    logic [EXP_W-1:0]   exp_inc;

    logic [EXP_W+MAN_W:0] res_d;
    logic [2:0]           flg_d;
    logic                 do_shift;

`ifdef FP_NORM_FAST_LZC_EN
    localparam int unsigned LZ_W  = $clog2(MAN_W + 2);
    localparam int unsigned CMP_W = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;

    logic [LZ_W-1:0]  lz;
    logic [CMP_W-1:0] lz_ext;
    logic [CMP_W-1:0] room;
    logic [CMP_W-1:0] shamt;

    fp_lzc #(
        .W (MAN_W + 1)
    ) u_lzc (
        .din (sum_q[MAN_W:0]),
        .cnt (lz)
    );

    // Shift only where the iterative build would shift; clamp so exp stops at 1.
    always_comb begin
        lz_ext = CMP_W'(lz);
        room   = CMP_W'(exp_q) - CMP_W'(1);
        shamt  = '0;
        if (exp_q != EXP_ONES && sum_q != '0 && !sum_q[MAN_W+1] && !sum_q[MAN_W]
            && exp_q > EXP_W'(1)) begin
            shamt = (lz_ext < room) ? lz_ext : room;
        end
        n_sum = sum_q << shamt;
        n_exp = exp_q - EXP_W'(shamt);
    end
`else
    assign n_sum = sum_q;
    assign n_exp = exp_q;
`endif

    assign exp_inc = n_exp + EXP_W'(1);

    // Priority: Inf/NaN, zero, carry, normalized, denormal, else keep shifting.
    always_comb begin
        res_d    = '0;
        flg_d    = '0;
        do_shift = 1'b0;
        if (n_exp == EXP_ONES) begin
            res_d = {sign_q, EXP_ONES, n_sum[MAN_W-1:0]};
        end else if (n_sum == '0) begin
            flg_d[FLAG_ZERO] = 1'b1;
        end else if (n_sum[MAN_W+1]) begin
            if (exp_inc == EXP_ONES) begin
                res_d           = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
                flg_d[FLAG_OVF] = 1'b1;
            end else begin
                res_d = {sign_q, exp_inc, n_sum[MAN_W:1]};
            end
        end else if (n_sum[MAN_W]) begin
            res_d = {sign_q, n_exp, n_sum[MAN_W-1:0]};
        end else if (n_exp <= EXP_W'(1)) begin
            res_d           = {sign_q, {EXP_W{1'b0}}, n_sum[MAN_W-1:0]};
            flg_d[FLAG_UNF] = (n_exp == EXP_W'(1));
        end else begin
            do_shift = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            sum_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= in_sign;
                        exp_q    <= in_exp;
                        sum_q    <= in_sum;
                        in_ready <= 1'b0;
                        state    <= NORM;
                    end
                end
                NORM: begin
                    if (do_shift) begin
                        sum_q <= sum_q << 1;
                        exp_q <= exp_q - EXP_W'(1);
                    end else begin
                        out_result <= res_d;
                        out_flags  <= flg_d;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises only after DONE has been left.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
